// File: rtl/keymgr_key_share_reg.sv
// -----------------------------------------------------------------------------
// keymgr_key_share_reg
//
// Holds a masked key as Shares x KeyWidth bit shares for the key manager and
// presents it to sideload consumers. Loading uses a valid/ready handshake.
// A clear request starts a multi-cycle wipe. The wipe first overwrites the
// shares with fresh entropy and then zeroises them, so no key material is
// left in the flops afterwards.
//
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   load_valid_i  load request
//   load_ready_o  high when a load can be accepted (low during a wipe)
//   load_key_i    incoming shares; share s is at [s*KeyWidth +: KeyWidth]
//   clear_i       wipe request, sampled every cycle
//   entropy_i     random data written into the shares while wiping
//   key_valid_o   key_o holds a loaded key
//   key_o         registered shares, packed the same way as load_key_i
//   key_xor_o     XOR of all shares (the unmasked key), test/debug tap
//   busy_o        wipe in progress
// -----------------------------------------------------------------------------
module keymgr_key_share_reg #(
    parameter int Shares     = 2,
    parameter int KeyWidth   = 16,
    parameter int WipeCycles = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         load_valid_i,
    output logic                         load_ready_o,
    input  logic [Shares*KeyWidth-1:0]   load_key_i,
    input  logic                         clear_i,
    input  logic [KeyWidth-1:0]          entropy_i,
    output logic                         key_valid_o,
    output logic [Shares*KeyWidth-1:0]   key_o,
    output logic [KeyWidth-1:0]          key_xor_o,
    output logic                         busy_o
);

    localparam int CntW = $clog2(WipeCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WipeCycles - 1);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_LOADED = 2'd1,
        ST_WIPE   = 2'd2
    } state_e;

    state_e                       state_q, state_d;
    logic [Shares*KeyWidth-1:0]   key_q, key_d;
    logic [CntW-1:0]              cnt_q, cnt_d;
    logic                         key_valid_q, key_valid_d;
    logic                         busy_q, busy_d;

    // Each share gets the entropy rotated left by a different amount. The
    // shares therefore differ from each other while the wipe runs, and their
    // XOR does not collapse to zero or to a plain copy of the entropy.
    logic [Shares*KeyWidth-1:0]   wipe_fill;

    for (genvar gi = 0; gi < Shares; gi++) begin : g_fill
        localparam int Rot = gi % KeyWidth;
        logic [2*KeyWidth-1:0] dbl;
        // Shifting a doubled copy right by (KeyWidth-Rot) leaves a left
        // rotation by Rot in the low half. This also holds for Rot == 0.
        assign dbl = {entropy_i, entropy_i} >> (KeyWidth - Rot);
        assign wipe_fill[gi*KeyWidth +: KeyWidth] = dbl[KeyWidth-1:0];
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_EMPTY, ST_LOADED: begin
                // A clear beats a load issued in the same cycle.
                if (clear_i) begin
                    state_d = ST_WIPE;
                    cnt_d   = '0;
                end else if (load_valid_i) begin
                    state_d = ST_LOADED;
                    key_d   = load_key_i;
                end
            end
            ST_WIPE: begin
                // clear_i and load_valid_i are ignored until the wipe ends.
                if (cnt_q == CntLast) begin
                    state_d = ST_EMPTY;
                    key_d   = '0;
                    cnt_d   = '0;
                end else begin
                    key_d = wipe_fill;
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = ST_EMPTY;
                key_d   = '0;
                cnt_d   = '0;
            end
        endcase
        // The status flags are registered copies of the next state, so the
        // outputs come straight from flops.
        key_valid_d = (state_d == ST_LOADED);
        busy_d      = (state_d == ST_WIPE);
    end

    // State and data registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_EMPTY;
            key_q       <= '0;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            cnt_q       <= cnt_d;
            key_valid_q <= key_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Unmasked view of the key
    always_comb begin
        key_xor_o = '0;
        for (int s = 0; s < Shares; s++) begin
            key_xor_o = key_xor_o ^ key_q[s*KeyWidth +: KeyWidth];
        end
    end

    assign load_ready_o = (state_q != ST_WIPE);
    assign key_valid_o  = key_valid_q;
    assign busy_o       = busy_q;
    assign key_o        = key_q;

endmodule

// File: tb/tb_keymgr_key_share_reg.sv
module tb_keymgr_key_share_reg;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: Shares=2, KeyWidth=16, WipeCycles=4
    logic        a_lv, a_ready, a_clr, a_valid, a_busy;
    logic [31:0] a_lk, a_key;
    logic [15:0] a_ent, a_xor;

    keymgr_key_share_reg #(.Shares(2), .KeyWidth(16), .WipeCycles(4)) dut_a (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .load_valid_i (a_lv),
        .load_ready_o (a_ready),
        .load_key_i   (a_lk),
        .clear_i      (a_clr),
        .entropy_i    (a_ent),
        .key_valid_o  (a_valid),
        .key_o        (a_key),
        .key_xor_o    (a_xor),
        .busy_o       (a_busy)
    );

    // Instance B: Shares=3, KeyWidth=8, WipeCycles=1
    logic        b_lv, b_ready, b_clr, b_valid, b_busy;
    logic [23:0] b_lk, b_key;
    logic [7:0]  b_ent, b_xor;

    keymgr_key_share_reg #(.Shares(3), .KeyWidth(8), .WipeCycles(1)) dut_b (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .load_valid_i (b_lv),
        .load_ready_o (b_ready),
        .load_key_i   (b_lk),
        .clear_i      (b_clr),
        .entropy_i    (b_ent),
        .key_valid_o  (b_valid),
        .key_o        (b_key),
        .key_xor_o    (b_xor),
        .busy_o       (b_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        lv;
        logic [31:0] lk;
        logic        clr;
        logic [15:0] ent;
        logic        valid;
        logic        ready;
        logic        busy;
        logic [31:0] key;
        logic [15:0] kx;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    initial begin
        // inputs: lv, lk, clr, ent | expected after the edge: valid, ready, busy, key, xor
        vecs[0]  = '{1'b1, 32'hA5A50F0F, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 32'hA5A50F0F, 16'hAAAA};
        vecs[1]  = '{1'b1, 32'h12345678, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 32'h12345678, 16'h444C};
        vecs[2]  = '{1'b0, 32'h00000000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 32'h12345678, 16'h444C};
        vecs[3]  = '{1'b0, 32'h00000000, 1'b1, 16'h8001, 1'b0, 1'b0, 1'b1, 32'h12345678, 16'h444C};
        vecs[4]  = '{1'b0, 32'h00000000, 1'b0, 16'h8001, 1'b0, 1'b0, 1'b1, 32'h00038001, 16'h8002};
        vecs[5]  = '{1'b0, 32'h00000000, 1'b0, 16'h8001, 1'b0, 1'b0, 1'b1, 32'h00038001, 16'h8002};
        vecs[6]  = '{1'b0, 32'h00000000, 1'b0, 16'h8001, 1'b0, 1'b0, 1'b1, 32'h00038001, 16'h8002};
        vecs[7]  = '{1'b0, 32'h00000000, 1'b0, 16'h8001, 1'b0, 1'b1, 1'b0, 32'h00000000, 16'h0000};
        vecs[8]  = '{1'b1, 32'hDEADBEEF, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 16'h6042};
        vecs[9]  = '{1'b1, 32'hCAFEF00D, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 16'h6042};
        vecs[10] = '{1'b1, 32'hCAFEF00D, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 32'h24681234, 16'h365C};
        vecs[11] = '{1'b1, 32'hCAFEF00D, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 32'h24681234, 16'h365C};
        vecs[12] = '{1'b1, 32'hCAFEF00D, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 32'h24681234, 16'h365C};
        vecs[13] = '{1'b1, 32'hCAFEF00D, 1'b0, 16'h1234, 1'b0, 1'b1, 1'b0, 32'h00000000, 16'h0000};
        vecs[14] = '{1'b1, 32'hCAFEF00D, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 32'hCAFEF00D, 16'h3AF3};
    end

    initial begin
        int n;
        rst_n = 1'b0;
        a_lv = 1'b0; a_lk = '0; a_clr = 1'b0; a_ent = '0;
        b_lv = 1'b0; b_lk = '0; b_clr = 1'b0; b_ent = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset valid", {31'd0, a_valid}, 32'd0);
        chk("reset busy",  {31'd0, a_busy},  32'd0);
        chk("reset ready", {31'd0, a_ready}, 32'd1);
        chk("reset key",   a_key, 32'd0);
        chk("reset xor",   {16'd0, a_xor}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset ready", {31'd0, a_ready}, 32'd1);

        // Table-driven load / wipe / priority sequence on instance A
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            a_lv  = vecs[i].lv;
            a_lk  = vecs[i].lk;
            a_clr = vecs[i].clr;
            a_ent = vecs[i].ent;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d valid", i), {31'd0, a_valid}, {31'd0, vecs[i].valid});
            chk($sformatf("v%0d ready", i), {31'd0, a_ready}, {31'd0, vecs[i].ready});
            chk($sformatf("v%0d busy", i),  {31'd0, a_busy},  {31'd0, vecs[i].busy});
            chk($sformatf("v%0d key", i),   a_key, vecs[i].key);
            chk($sformatf("v%0d xor", i),   {16'd0, a_xor}, {16'd0, vecs[i].kx});
            $display("vector %0d: lv=%b clr=%b key=%h xor=%h busy=%b", i, a_lv, a_clr, a_key, a_xor, a_busy);
        end
        @(negedge clk);
        a_lv = 1'b0;

        // Reset asserted in the middle of a wipe
        a_clr = 1'b1; a_ent = 16'h8001;
        @(negedge clk);
        a_clr = 1'b0;
        @(posedge clk);
        #3;
        chk("midwipe busy before reset", {31'd0, a_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async rst valid", {31'd0, a_valid}, 32'd0);
        chk("async rst busy",  {31'd0, a_busy},  32'd0);
        chk("async rst ready", {31'd0, a_ready}, 32'd1);
        chk("async rst key",   a_key, 32'd0);
        chk("async rst xor",   {16'd0, a_xor}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("after rst ready", {31'd0, a_ready}, 32'd1);
        chk("after rst busy",  {31'd0, a_busy},  32'd0);
        chk("after rst key",   a_key, 32'd0);
        $display("reset mid-wipe: key=%h ready=%b", a_key, a_ready);

        // Clear from EMPTY still runs the full wipe; busy counted with a bound
        @(negedge clk);
        a_clr = 1'b1;
        @(posedge clk);
        #1;
        a_clr = 1'b0;
        n = a_busy ? 1 : 0;
        for (int c = 0; c < 10; c++) begin
            if (!a_busy) break;
            @(posedge clk);
            #1;
            if (a_busy) n++;
        end
        chk("empty clear busy cycles", n, 32'd4);
        chk("empty clear end key",   a_key, 32'd0);
        chk("empty clear end ready", {31'd0, a_ready}, 32'd1);
        $display("clear from empty: busy cycles=%0d", n);

        // Instance B: three 8-bit shares, single-cycle zeroise
        @(negedge clk);
        b_lv = 1'b1; b_lk = 24'hFF00AA;
        @(posedge clk);
        #1;
        chk("B load valid", {31'd0, b_valid}, 32'd1);
        chk("B load key",   {8'd0, b_key}, 32'h00FF00AA);
        chk("B load xor",   {24'd0, b_xor}, 32'h55);
        $display("B load: key=%h xor=%h", b_key, b_xor);
        @(negedge clk);
        b_lv = 1'b0; b_clr = 1'b1; b_ent = 8'h5A;
        @(posedge clk);
        #1;
        chk("B wipe busy",  {31'd0, b_busy},  32'd1);
        chk("B wipe valid", {31'd0, b_valid}, 32'd0);
        chk("B wipe ready", {31'd0, b_ready}, 32'd0);
        @(negedge clk);
        b_clr = 1'b0;
        @(posedge clk);
        #1;
        chk("B done busy",  {31'd0, b_busy},  32'd0);
        chk("B done key",   {8'd0, b_key}, 32'd0);
        chk("B done ready", {31'd0, b_ready}, 32'd1);
        $display("B wipe: key=%h busy=%b", b_key, b_busy);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Overall time bound in case something stalls
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
